ib_flow_ctrl: RTL

//  Sequencer for the instruction buffer (IB), placed between IF, IB and dispatch.
//  - Throttles fetch with a credit scheme (IB occupancy + fetches in flight).
//  - Decides each cycle whether the IB head dispatches, from ROB/RS/free-list room.
//  - On a mispredict: one-cycle IB squash, fetch redirect, then a fixed recovery window.

---
 rtl/ib_flow_ctrl_pkg.sv | 33 +++
 rtl/ib_flow_ctrl_if.sv | 53 +++++
 rtl/ib_flow_ctrl_counter.sv | 40 ++++
 rtl/ib_flow_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ib_flow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ib_flow_ctrl_pkg
// Shared definitions for the instruction-buffer flow controller: buffer depth,
// fetch latency, recovery window length, counter widths and the controller
// state enum. The credit helper is shared so every user computes the fetch
// credit at the same widened width.
// ---------------------------------------------------------------------------
package ib_flow_ctrl_pkg;

    localparam int IBUFFER_SZ     = 8;
    localparam int FETCH_LAT      = 2;
    localparam int RECOVER_CYCLES = 2;
    localparam int CNT_W          = $clog2(IBUFFER_SZ) + 1;
    localparam int RCNT_W         = $clog2(RECOVER_CYCLES + 1);

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [RCNT_W-1:0] rcnt_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SQUASH  = 2'd1,
        RECOVER = 2'd2
    } ib_ctrl_state_e;

    // True while buffered packets plus packets still in the fetch pipe leave
    // room for one more fetch. The sum is one bit wider so it cannot wrap.
    function automatic logic credit_avail(input cnt_t occ, input cnt_t inflight);
        logic [CNT_W:0] sum;
        sum = {1'b0, occ} + {1'b0, inflight};
        return sum < (CNT_W + 1)'(IBUFFER_SZ);
    endfunction

endpackage

// File: rtl/ib_flow_ctrl_if.sv
// ---------------------------------------------------------------------------
// ib_flow_ctrl_if
// Bundles the controller's handshake signals towards IF, IB, dispatch and
// retire. The slave modport is the controller's view; master is the view of
// the surrounding pipeline (or a testbench standing in for it).
//   if_valid_in       IF delivers a packet to the IB
//   ib_head_valid     IB head packet is valid
//   ib_head_has_dest  IB head writes a destination register
//   rob/rs/fl_free_cnt  free ROB entries, RS entries, physical registers
//   mispredict_in/pc  retire-stage mispredict pulse and correct target
//   fetch_req         IF may start a fetch
//   dispatch_valid    pop the IB head into dispatch
//   ib_squash         clear the IB
//   redirect_valid/pc IF redirect strobe and target
//   occ_out           controller's view of IB occupancy
//   overflow_err      sticky: packet arrived into a full IB
// ---------------------------------------------------------------------------
interface ib_flow_ctrl_if;
    import ib_flow_ctrl_pkg::*;

    logic        if_valid_in;
    logic        ib_head_valid;
    logic        ib_head_has_dest;
    cnt_t        rob_free_cnt;
    cnt_t        rs_free_cnt;
    cnt_t        fl_free_cnt;
    logic        mispredict_in;
    logic [31:0] mispredict_pc;
    logic        fetch_req;
    logic        dispatch_valid;
    logic        ib_squash;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    cnt_t        occ_out;
    logic        overflow_err;

    modport master (
        output if_valid_in, ib_head_valid, ib_head_has_dest,
               rob_free_cnt, rs_free_cnt, fl_free_cnt,
               mispredict_in, mispredict_pc,
        input  fetch_req, dispatch_valid, ib_squash, redirect_valid,
               redirect_pc, occ_out, overflow_err
    );

    modport slave (
        input  if_valid_in, ib_head_valid, ib_head_has_dest,
               rob_free_cnt, rs_free_cnt, fl_free_cnt,
               mispredict_in, mispredict_pc,
        output fetch_req, dispatch_valid, ib_squash, redirect_valid,
               redirect_pc, occ_out, overflow_err
    );

endinterface

// File: rtl/ib_flow_ctrl_counter.sv
// ---------------------------------------------------------------------------
// ib_flow_ctrl_counter
// Up/down counter bounded to 0..IBUFFER_SZ with a synchronous clear.
//   clock    system clock
//   reset    synchronous, active-low
//   i_clr    clear to zero (wins over inc/dec)
//   i_inc    count up one
//   i_dec    count down one
//   o_count  current value
// ---------------------------------------------------------------------------
module ib_flow_ctrl_counter
    import ib_flow_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_dec,
    output cnt_t o_count
);

    cnt_t r_count;

    // Simultaneous inc and dec cancel. Saturating at both ends means a stray
    // decrement or an arrival into a full buffer can never wrap the count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != cnt_t'(IBUFFER_SZ))) begin
            r_count <= r_count + cnt_t'(1);
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - cnt_t'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ib_flow_ctrl.sv
// ---------------------------------------------------------------------------
// ib_flow_ctrl
// Sequencer between IF, the instruction buffer and dispatch. Throttles fetch
// with a credit scheme (occupancy + fetches in flight), decides each cycle
// whether the IB head dispatches, and on a mispredict squashes the IB for one
// cycle, redirects fetch, then holds everything for a recovery window.
//   clock    system clock
//   reset    synchronous, active-low
//   io_bus   controller side of ib_flow_ctrl_if (see interface header)
// ---------------------------------------------------------------------------
module ib_flow_ctrl
    import ib_flow_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    ib_flow_ctrl_if.slave   io_bus
);

    ib_ctrl_state_e r_state;
    ib_ctrl_state_e w_nextState;
    rcnt_t          r_rcnt;
    rcnt_t          w_nextRcnt;
    logic [31:0]    r_redirectPc;
    logic [31:0]    w_nextRedirectPc;
    logic           r_overflow;

    cnt_t           w_occ;
    cnt_t           w_inflight;
    logic           w_runOk;
    logic           w_fetchReq;
    logic           w_dispatch;
    logic           w_squashing;
    logic           w_arrival;
    logic           w_roomOk;

    // State register. Reset drops any pending redirect immediately.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= RUN;
            r_rcnt       <= '0;
            r_redirectPc <= '0;
        end else begin
            r_state      <= w_nextState;
            r_rcnt       <= w_nextRcnt;
            r_redirectPc <= w_nextRedirectPc;
        end
    end

    // Next-state and strobe logic. A mispredict from any state (including a
    // squash already in progress) restarts the squash with the newest PC.
    // Strobes are forced low while reset is held so the pipeline sees a
    // quiet controller for the whole reset window.
    always_comb begin
        w_nextState      = r_state;
        w_nextRcnt       = r_rcnt;
        w_nextRedirectPc = r_redirectPc;
        w_runOk          = 1'b0;
        w_fetchReq       = 1'b0;
        w_dispatch       = 1'b0;
        w_squashing      = 1'b0;
        w_roomOk         = 1'b0;

        if (io_bus.mispredict_in) begin
            w_nextState      = SQUASH;
            w_nextRedirectPc = io_bus.mispredict_pc;
        end else begin
            case (r_state)
                RUN: begin
                    w_nextState = RUN;
                end
                SQUASH: begin
                    w_nextState = RECOVER;
                    w_nextRcnt  = rcnt_t'(RECOVER_CYCLES - 1);
                end
                RECOVER: begin
                    if (r_rcnt == '0) begin
                        w_nextState = RUN;
                    end else begin
                        w_nextRcnt = r_rcnt - rcnt_t'(1);
                    end
                end
                default: begin
                    w_nextState = RUN;
                end
            endcase
        end

        w_runOk     = reset && (r_state == RUN) && !io_bus.mispredict_in;
        w_squashing = reset && (r_state == SQUASH);
        w_fetchReq  = w_runOk && credit_avail(w_occ, w_inflight);
        w_roomOk    = (io_bus.rob_free_cnt != '0) && (io_bus.rs_free_cnt != '0) &&
                      (!io_bus.ib_head_has_dest || (io_bus.fl_free_cnt != '0));
        w_dispatch  = w_runOk && (w_occ != '0) && io_bus.ib_head_valid && w_roomOk;
    end

    // Packets only count while running; during squash/recovery IF is
    // discarding its pipe, so anything that shows up is ignored.
    assign w_arrival = (r_state == RUN) && io_bus.if_valid_in;

    // Sticky error: a counted arrival found the buffer already full.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_arrival && (w_occ == cnt_t'(IBUFFER_SZ))) begin
            r_overflow <= 1'b1;
        end
    end

    ib_flow_ctrl_counter u_occCnt (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (io_bus.mispredict_in),
        .i_inc   (w_arrival),
        .i_dec   (w_dispatch),
        .o_count (w_occ)
    );

    ib_flow_ctrl_counter u_inflightCnt (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (io_bus.mispredict_in),
        .i_inc   (w_fetchReq),
        .i_dec   (w_arrival),
        .o_count (w_inflight)
    );

    assign io_bus.fetch_req      = w_fetchReq;
    assign io_bus.dispatch_valid = w_dispatch;
    assign io_bus.ib_squash      = w_squashing;
    assign io_bus.redirect_valid = w_squashing;
    assign io_bus.redirect_pc    = w_squashing ? r_redirectPc : 32'h0;
    assign io_bus.occ_out        = w_occ;
    assign io_bus.overflow_err   = r_overflow;

endmodule
